// File: rtl/medidor_desempenho_mem_arbiter.sv
// Two-master arbiter in front of the single-port on-chip data memory.
// m0 is the Nios II data master and m1 is the performance logger.
// One access is issued per cycle. Read data returns one cycle later and is
// tagged to the port that issued it. Per-port saturating stall counters are
// kept for the measurement software.
module medidor_desempenho_mem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // master 0 (Nios II data master)
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  // master 1 (performance logger)
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  // memory slave
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  // statistics
  input  logic              clr_stats,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
);

  localparam logic [3:0]  STARVE_LIM_C = 4'(STARVE_LIMIT);
  localparam logic [3:0]  STARVE_MAX_C = 4'hF;
  localparam logic [31:0] STALL_MAX_C  = 32'hFFFF_FFFF;

  logic        req0, req1;
  logic        grant0, grant1;
  logic        wait0, wait1;

  logic        last_grant_q, last_grant_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rd_vld_q, rd_vld_d;
  logic        rd_port_q, rd_port_d;
  logic [31:0] stall_cnt0_q, stall_cnt0_d;
  logic [31:0] stall_cnt1_q, stall_cnt1_d;

  // A write with read also high is still a single request (treated as write).
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Pick at most one port; ties resolved by round-robin or by m0 priority
  // with a starvation escape for m1.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      if (PRIO_MODE == 0) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else begin
        if (starve_cnt_q >= STARVE_LIM_C) grant1 = 1'b1;
        else                              grant0 = 1'b1;
      end
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  assign wait0          = req0 & ~grant0;
  assign wait1          = req1 & ~grant1;
  assign m0_waitrequest = wait0;
  assign m1_waitrequest = wait1;

  // Drive the memory from the granted port; all zero when idle.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  // Next-state for arbitration history, read tagging and stall statistics.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;

    starve_cnt_d = '0;
    if (wait1) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX_C) ? starve_cnt_q
                                                    : starve_cnt_q + 4'd1;
    end

    // A granted access that is not a write must be a read.
    rd_vld_d  = (grant0 & ~m0_write) | (grant1 & ~m1_write);
    rd_port_d = grant1;

    stall_cnt0_d = stall_cnt0_q;
    stall_cnt1_d = stall_cnt1_q;
    if (clr_stats) begin
      stall_cnt0_d = '0;
      stall_cnt1_d = '0;
    end else begin
      if (wait0 && (stall_cnt0_q != STALL_MAX_C)) stall_cnt0_d = stall_cnt0_q + 32'd1;
      if (wait1 && (stall_cnt1_q != STALL_MAX_C)) stall_cnt1_d = stall_cnt1_q + 32'd1;
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      starve_cnt_q <= '0;
      rd_vld_q     <= 1'b0;
      rd_port_q    <= 1'b0;
      stall_cnt0_q <= '0;
      stall_cnt1_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_port_q    <= rd_port_d;
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

  // Read data is shared; the valid strobe tags it to the issuing port.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld_q & ~rd_port_q;
  assign m1_readdatavalid = rd_vld_q &  rd_port_q;

  assign stall_cnt0 = stall_cnt0_q;
  assign stall_cnt1 = stall_cnt1_q;

endmodule

// File: tb/tb_medidor_desempenho_mem_arbiter.sv
// Bench for medidor_desempenho_mem_arbiter: a round-robin instance (index 0)
// and a fixed-priority instance (index 1) share stimulus, each with its own
// memory slave, checked against a behavioural model of the arbitration rules.
module tb_medidor_desempenho_mem_arbiter;
  localparam int AW    = 11;
  localparam int DEPTH = 2 ** AW;
  localparam int SL    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clr_stats, ram_clr;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_be, m1_be;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_wd, m1_wd;

  logic [1:0]    w0, w1, rv0, rv1, cs, mwr, ck;
  logic [31:0]   rd0 [2], rd1 [2], mwd [2], mrd [2], sc0 [2], sc1 [2];
  logic [AW-1:0] maddr [2];
  logic [3:0]    mbe [2];

  medidor_desempenho_mem_arbiter #(.ADDR_W(AW), .PRIO_MODE(0), .STARVE_LIMIT(SL)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_be), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_wd), .m0_waitrequest(w0[0]), .m0_readdata(rd0[0]), .m0_readdatavalid(rv0[0]),
    .m1_address(m1_address), .m1_byteenable(m1_be), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_wd), .m1_waitrequest(w1[0]), .m1_readdata(rd1[0]), .m1_readdatavalid(rv1[0]),
    .mem_address(maddr[0]), .mem_byteenable(mbe[0]), .mem_chipselect(cs[0]), .mem_write(mwr[0]),
    .mem_writedata(mwd[0]), .mem_clken(ck[0]), .mem_readdata(mrd[0]),
    .clr_stats(clr_stats), .stall_cnt0(sc0[0]), .stall_cnt1(sc1[0]));

  medidor_desempenho_mem_arbiter #(.ADDR_W(AW), .PRIO_MODE(1), .STARVE_LIMIT(SL)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_be), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_wd), .m0_waitrequest(w0[1]), .m0_readdata(rd0[1]), .m0_readdatavalid(rv0[1]),
    .m1_address(m1_address), .m1_byteenable(m1_be), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_wd), .m1_waitrequest(w1[1]), .m1_readdata(rd1[1]), .m1_readdatavalid(rv1[1]),
    .mem_address(maddr[1]), .mem_byteenable(mbe[1]), .mem_chipselect(cs[1]), .mem_write(mwr[1]),
    .mem_writedata(mwd[1]), .mem_clken(ck[1]), .mem_readdata(mrd[1]),
    .clr_stats(clr_stats), .stall_cnt0(sc0[1]), .stall_cnt1(sc1[1]));

  // Memory slaves: byte-lane writes, registered read data.
  logic [31:0] ram [2][DEPTH];
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (ram_clr) begin
        mrd[m] <= '0;
        for (int a = 0; a < DEPTH; a++) ram[m][a] <= '0;
      end else if (cs[m]) begin
        if (mwr[m]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[m][b]) ram[m][maddr[m]][8*b +: 8] <= mwd[m][8*b +: 8];
        end else begin
          mrd[m] <= ram[m][maddr[m]];
        end
      end
    end
  end

  // Reference model state
  int          mlast [2];
  int          mstarve [2];
  logic [31:0] mst0 [2], mst1 [2];
  logic [31:0] rmem [2][DEPTH];
  bit          ev0 [2], ev1 [2];
  logic [31:0] edata [2];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int model_grant(int m);
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (r0 && r1) begin
      if (m == 0) return (mlast[m] == 0) ? 1 : 0;
      return (mstarve[m] >= SL) ? 1 : 0;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset(int m);
    mlast[m]   = 1;
    mstarve[m] = 0;
    mst0[m]    = '0;
    mst1[m]    = '0;
    ev0[m]     = 1'b0;
    ev1[m]     = 1'b0;
  endtask

  // Advance one clock and move the model with it; returns 1ns after the edge.
  task automatic cycle();
    int g [2];
    bit r0, r1, wt0, wt1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    for (int m = 0; m < 2; m++) g[m] = model_grant(m);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      wt0 = r0 && (g[m] != 0);
      wt1 = r1 && (g[m] != 1);
      ev0[m] = (g[m] == 0) && !m0_write;
      ev1[m] = (g[m] == 1) && !m1_write;
      if (g[m] == 0) begin
        if (m0_write) begin
          for (int b = 0; b < 4; b++) if (m0_be[b]) rmem[m][m0_address][8*b +: 8] = m0_wd[8*b +: 8];
        end else edata[m] = rmem[m][m0_address];
      end
      if (g[m] == 1) begin
        if (m1_write) begin
          for (int b = 0; b < 4; b++) if (m1_be[b]) rmem[m][m1_address][8*b +: 8] = m1_wd[8*b +: 8];
        end else edata[m] = rmem[m][m1_address];
      end
      if (clr_stats) begin
        mst0[m] = '0;
        mst1[m] = '0;
      end else begin
        if (wt0 && mst0[m] != 32'hFFFF_FFFF) mst0[m] = mst0[m] + 32'd1;
        if (wt1 && mst1[m] != 32'hFFFF_FFFF) mst1[m] = mst1[m] + 32'd1;
      end
      mstarve[m] = wt1 ? ((mstarve[m] < 15) ? mstarve[m] + 1 : 15) : 0;
      if (g[m] >= 0) mlast[m] = g[m];
      if (reset) model_reset(m);
    end
    #1;
  endtask

  task automatic set_idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_be = '0; m0_wd = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_be = '0; m1_wd = '0;
    clr_stats = 0;
  endtask

  task automatic set_both_read(logic [AW-1:0] a0, logic [AW-1:0] a1);
    m0_read = 1; m0_write = 0; m0_address = a0; m0_be = 4'hF;
    m1_read = 1; m1_write = 0; m1_address = a1; m1_be = 4'hF;
  endtask

  task automatic reset_pulse();
    set_idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1; ram_clr = 1;
    cycle();
    ram_clr = 0;
    cycle();
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (rv0[m] !== 1'b0 || rv1[m] !== 1'b0) begin n_err++; $display("FAIL reset_rdvalid[%0d]: got %b%b expected 00", m, rv0[m], rv1[m]); end
      n_vec++; if (sc0[m] !== 32'd0 || sc1[m] !== 32'd0) begin n_err++; $display("FAIL reset_stall[%0d]: got %h/%h expected 0/0", m, sc0[m], sc1[m]); end
      n_vec++; if (ck[m] !== 1'b1) begin n_err++; $display("FAIL clken[%0d]: got %b expected 1", m, ck[m]); end
    end
    reset = 0;
    #1;
  endtask

  task automatic test_write_then_read();
    set_idle();
    m0_write = 1; m0_address = 11'h005; m0_be = 4'hF; m0_wd = 32'hDEADBEEF;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (w0[m] !== 1'b0) begin n_err++; $display("FAIL wr_wait[%0d]: got %b expected 0", m, w0[m]); end
    end
    cycle();
    m0_write = 0; m0_read = 1; m0_wd = '0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (w0[m] !== 1'b0 || rv0[m] !== 1'b0 || rv1[m] !== 1'b0) begin n_err++; $display("FAIL rd_issue[%0d]: got wait=%b rv=%b%b expected 0 00", m, w0[m], rv0[m], rv1[m]); end
    end
    cycle();
    set_idle();
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (rv0[m] !== 1'b1 || rd0[m] !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_data[%0d]: got v=%b %h expected v=1 deadbeef", m, rv0[m], rd0[m]); end
      n_vec++; if (rv1[m] !== 1'b0) begin n_err++; $display("FAIL raw_m1valid[%0d]: got %b expected 0", m, rv1[m]); end
    end
    cycle();
  endtask

  task automatic test_round_robin();
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      set_both_read(11'h005, 11'h006);
      #1;
      n_vec++; if (w0[0] !== 1'(k % 2) || w1[0] !== 1'(1 - k % 2)) begin n_err++; $display("FAIL rr_grant k=%0d: got wait=%b%b expected %b%b", k, w0[0], w1[0], 1'(k % 2), 1'(1 - k % 2)); end
      cycle();
      n_vec++; if (rv0[0] !== 1'(1 - k % 2) || rv1[0] !== 1'(k % 2)) begin n_err++; $display("FAIL rr_valid k=%0d: got %b%b expected %b%b", k, rv0[0], rv1[0], 1'(1 - k % 2), 1'(k % 2)); end
      if (k % 2 == 0) begin
        n_vec++; if (rd0[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rr_data0 k=%0d: got %h expected deadbeef", k, rd0[0]); end
      end
    end
    n_vec++; if (sc0[0] !== 32'd3 || sc1[0] !== 32'd3) begin n_err++; $display("FAIL rr_stalls: got %0d/%0d expected 3/3", sc0[0], sc1[0]); end
    set_idle();
    cycle();
  endtask

  task automatic test_fixed_priority();
    reset_pulse();
    for (int k = 0; k < 10; k++) begin
      set_both_read(11'h010, 11'h011);
      #1;
      n_vec++; if (dut_fp.starve_cnt_q !== 4'(k % 5)) begin n_err++; $display("FAIL fp_starve k=%0d: got %0d expected %0d", k, dut_fp.starve_cnt_q, k % 5); end
      n_vec++; if (w0[1] !== 1'(k % 5 == 4) || w1[1] !== 1'(k % 5 != 4)) begin n_err++; $display("FAIL fp_grant k=%0d: got wait=%b%b", k, w0[1], w1[1]); end
      cycle();
      n_vec++; if (rv1[1] !== 1'(k % 5 == 4) || rv0[1] !== 1'(k % 5 != 4)) begin n_err++; $display("FAIL fp_valid k=%0d: got %b%b", k, rv0[1], rv1[1]); end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_byte_lanes();
    set_idle();
    m1_write = 1; m1_address = 11'h020; m1_be = 4'hF; m1_wd = 32'hAABBCCDD;
    cycle();
    m1_be = 4'b0101; m1_wd = 32'h11223344;
    cycle();
    m1_write = 0; m1_read = 1; m1_be = 4'hF; m1_wd = '0;
    cycle();
    set_idle();
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (rv1[m] !== 1'b1 || rd1[m] !== 32'hAA22CC44) begin n_err++; $display("FAIL byte_lanes[%0d]: got v=%b %h expected v=1 aa22cc44", m, rv1[m], rd1[m]); end
    end
    cycle();
  endtask

  task automatic test_reset_mid_read();
    set_idle();
    m1_read = 1; m1_address = 11'h020; m1_be = 4'hF;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (w1[m] !== 1'b0) begin n_err++; $display("FAIL mid_accept[%0d]: got %b expected 0", m, w1[m]); end
    end
    @(negedge clk);
    reset = 1;
    cycle();
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (rv1[m] !== 1'b0) begin n_err++; $display("FAIL mid_dropped[%0d]: got %b expected 0", m, rv1[m]); end
    end
    m1_read = 0;
    cycle();
    reset = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (rv1[m] !== 1'b0 || sc0[m] !== 32'd0 || sc1[m] !== 32'd0) begin n_err++; $display("FAIL post_reset[%0d]: got v=%b stalls %h/%h expected 0 0/0", m, rv1[m], sc0[m], sc1[m]); end
    end
    set_both_read(11'h001, 11'h002);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (w0[m] !== 1'b0 || w1[m] !== 1'b1) begin n_err++; $display("FAIL first_tie[%0d]: got wait=%b%b expected 01", m, w0[m], w1[m]); end
    end
    cycle();
    set_idle();
    cycle();
  endtask

  task automatic test_stall_saturation();
    set_idle();
    #1;
    force dut_rr.stall_cnt0_q = 32'hFFFF_FFFE;
    force dut_fp.stall_cnt1_q = 32'hFFFF_FFFE;
    #1;
    release dut_rr.stall_cnt0_q;
    release dut_fp.stall_cnt1_q;
    mst0[0] = 32'hFFFF_FFFE;
    mst1[1] = 32'hFFFF_FFFE;
    for (int k = 0; k < 6; k++) begin
      set_both_read(11'h003, 11'h004);
      cycle();
      n_vec++; if (sc0[0] !== mst0[0]) begin n_err++; $display("FAIL sat0 k=%0d: got %h expected %h", k, sc0[0], mst0[0]); end
      n_vec++; if (sc1[1] !== mst1[1]) begin n_err++; $display("FAIL sat1 k=%0d: got %h expected %h", k, sc1[1], mst1[1]); end
    end
    n_vec++; if (sc0[0] !== 32'hFFFF_FFFF || sc1[1] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %h/%h expected ffffffff/ffffffff", sc0[0], sc1[1]); end
    clr_stats = 1;
    cycle();
    clr_stats = 0;
    for (int m = 0; m < 2; m++) begin
      n_vec++; if (sc0[m] !== 32'd0 || sc1[m] !== 32'd0) begin n_err++; $display("FAIL clr_stats[%0d]: got %h/%h expected 0/0", m, sc0[m], sc1[m]); end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_random();
    int g, op;
    reset_pulse();
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 3);
      m0_read = (op == 1 || op == 3); m0_write = (op >= 2);
      m0_address = AW'($urandom_range(0, 15)); m0_be = 4'($urandom); m0_wd = $urandom;
      op = $urandom_range(0, 3);
      m1_read = (op == 1 || op == 3); m1_write = (op >= 2);
      m1_address = AW'($urandom_range(0, 15)); m1_be = 4'($urandom); m1_wd = $urandom;
      clr_stats = ($urandom_range(0, 31) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        g = model_grant(m);
        n_vec++; if (w0[m] !== 1'((m0_read | m0_write) && g != 0) || w1[m] !== 1'((m1_read | m1_write) && g != 1)) begin n_err++; $display("FAIL rnd_wait[%0d] k=%0d: got %b%b grant %0d", m, k, w0[m], w1[m], g); end
        n_vec++; if (cs[m] !== 1'(g >= 0)) begin n_err++; $display("FAIL rnd_cs[%0d] k=%0d: got %b expected %b", m, k, cs[m], 1'(g >= 0)); end
        n_vec++;
        if (g == 0 && (maddr[m] !== m0_address || mwr[m] !== m0_write || (m0_write && (mbe[m] !== m0_be || mwd[m] !== m0_wd)))) begin
          n_err++; $display("FAIL rnd_mem0[%0d] k=%0d: got a=%h w=%b expected a=%h w=%b", m, k, maddr[m], mwr[m], m0_address, m0_write);
        end else if (g == 1 && (maddr[m] !== m1_address || mwr[m] !== m1_write || (m1_write && (mbe[m] !== m1_be || mwd[m] !== m1_wd)))) begin
          n_err++; $display("FAIL rnd_mem1[%0d] k=%0d: got a=%h w=%b expected a=%h w=%b", m, k, maddr[m], mwr[m], m1_address, m1_write);
        end else if (g < 0 && (maddr[m] !== '0 || mwr[m] !== 1'b0 || mbe[m] !== '0 || mwd[m] !== '0)) begin
          n_err++; $display("FAIL rnd_idle[%0d] k=%0d: got a=%h w=%b expected 0", m, k, maddr[m], mwr[m]);
        end
      end
      cycle();
      for (int m = 0; m < 2; m++) begin
        n_vec++; if (rv0[m] !== ev0[m] || rv1[m] !== ev1[m]) begin n_err++; $display("FAIL rnd_valid[%0d] k=%0d: got %b%b expected %b%b", m, k, rv0[m], rv1[m], ev0[m], ev1[m]); end
        if (ev0[m]) begin
          n_vec++; if (rd0[m] !== edata[m]) begin n_err++; $display("FAIL rnd_rd0[%0d] k=%0d: got %h expected %h", m, k, rd0[m], edata[m]); end
        end
        if (ev1[m]) begin
          n_vec++; if (rd1[m] !== edata[m]) begin n_err++; $display("FAIL rnd_rd1[%0d] k=%0d: got %h expected %h", m, k, rd1[m], edata[m]); end
        end
        n_vec++; if (sc0[m] !== mst0[m] || sc1[m] !== mst1[m]) begin n_err++; $display("FAIL rnd_stall[%0d] k=%0d: got %0d/%0d expected %0d/%0d", m, k, sc0[m], sc1[m], mst0[m], mst1[m]); end
      end
    end
    set_idle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < DEPTH; a++) rmem[m][a] = '0;
      model_reset(m);
      edata[m] = '0;
    end
    set_idle();
    reset = 1; ram_clr = 1;
    test_reset();
    test_write_then_read();
    test_round_robin();
    test_fixed_priority();
    test_byte_lanes();
    test_reset_mid_read();
    test_stall_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/medidor_desempenho_mem_arbiter.md
Name: medidor_desempenho_mem_arbiter

Overview:
- Two-master arbiter sharing the single-port 2048x32 on-chip data memory.
- Port m0 serves the Nios II data master; port m1 serves the performance-measurement logger.
- Issues at most one access per cycle to the memory slave and returns read data with a fixed 1-cycle latency, tagged to the issuing port.
- Keeps saturating per-port stall counters for the measurement software.

Parameters:
- ADDR_W, 11, word address width; memory depth is 2**ADDR_W words.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority to m0 with starvation cap.
- STARVE_LIMIT, 4, PRIO_MODE=1 only: consecutive m1 wait cycles after which m1 is forced a grant; range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  word address, master 0.
- m0_byteenable  in  4  byte lanes, master 0.
- m0_read  in  1  read request, master 0.
- m0_write  in  1  write request, master 0.
- m0_writedata  in  32  write data, master 0.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  32  read data, master 0.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_*  same set as m0_*, for master 1.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  4  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  32  to memory writedata.
- mem_clken  out  1  to memory clken; tied to 1.
- mem_readdata  in  32  from memory readdata; valid the cycle after a read is issued.
- clr_stats  in  1  synchronous clear of both stall counters.
- stall_cnt0  out  32  saturating count of m0 wait cycles.
- stall_cnt1  out  32  saturating count of m1 wait cycles.

Behaviour:
- Request: reqX = mX_read | mX_write. If read and write are both high, the access is treated as a write.
- Grant (combinational, one port per cycle):
  - Only one port requesting: that port is granted.
  - Both requesting, PRIO_MODE=0: the port other than last_grant wins. last_grant resets to 1, so m0 wins the first tie.
  - Both requesting, PRIO_MODE=1: m0 wins unless starve_cnt >= STARVE_LIMIT, then m1 wins.
- starve_cnt (4 bit):
  - Increments each cycle m1 requests and is not granted.
  - Clears on an m1 grant, or when m1 is not requesting.
  - Reset value 0.
- Waitrequest: mX_waitrequest = reqX & ~grantX, combinational. Zero-wait when uncontended.
- Memory drive:
  - mem_chipselect = grant0 | grant1.
  - mem_address, mem_byteenable, mem_writedata and mem_write are muxed from the granted port.
  - With no grant, these outputs are 0.
- Read return pipeline:
  - Register rd_vld and rd_port, loaded every cycle. rd_vld = granted access is a read; rd_port = winning port.
  - mX_readdatavalid = rd_vld & (rd_port == X).
  - mX_readdata = mem_readdata, unconditionally passed through. Valid only when qualified by readdatavalid.
- Latency:
  - Read accepted in cycle N produces readdatavalid in cycle N+1.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- Writes: complete in the accept cycle; no response is generated.
- Read-after-write to the same address in consecutive cycles returns the new data. The memory commits the write at the edge ending cycle N.
- Stall counters:
  - stall_cntX increments every cycle mX_waitrequest = 1.
  - Saturates at 32'hFFFFFFFF.
  - clr_stats has priority over increment; the counter reads 0 the next cycle.
- Reset (asynchronous), all registers cleared:
  - rd_vld = 0, last_grant = 1, starve_cnt = 0, stall counters = 0.
  - Outputs: readdatavalid = 0, stall counters = 0. Combinational outputs follow their inputs.
- Reset asserted mid-read: the pending rd_vld is dropped; no readdatavalid is ever produced for that read.

Test Plan:
- m0 writes 0xDEADBEEF to addr 0x005 (byteenable 0xF), then reads 0x005 next cycle -> waitrequest 0 both cycles; m0_readdatavalid=1 one cycle after the read with data 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 6 cycles, PRIO_MODE=0 -> grants alternate m0,m1,m0,m1,m0,m1. Each readdatavalid pulses on the matching port one cycle after its grant. stall_cnt0=3, stall_cnt1=3 while both requesters stay asserted.
- PRIO_MODE=1, STARVE_LIMIT=4, both requesting continuously -> m0 granted 4 cycles, m1 granted the 5th, pattern repeats; starve_cnt returns to 0 after each m1 grant.
- Byte lanes: m1 writes 0x11223344 with byteenable 4'b0101 over an existing 0xAABBCCDD -> subsequent read returns 0xAA22CC44.
- Assert reset one cycle after an m1 read is accepted -> no m1_readdatavalid pulse. After deassert: stall counters 0, and the first tied request is granted to m0.
- Force stall_cnt0 to 0xFFFFFFFE, hold m0 stalled 3 cycles -> value holds at 0xFFFFFFFF. Pulse clr_stats together with a stall cycle -> value 0 next cycle.
